tone_generator_tdm: RTL and testbench

//  Time-multiplexed, N-voice phase-accumulator tone generator: one shared adder and

---
 rtl/tone_generator_tdm.sv | 198 +++++++++++++++++++
 tb/tb_tone_generator_tdm.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_generator_tdm.sv
// Time-multiplexed N-voice phase-accumulator tone generator: one shared adder and
// waveform datapath swept across all voice states once per sample_tick.
module tone_generator_tdm #(
    parameter int VOICES           = 4,
    parameter int FREQ_BITS        = 16,
    parameter int PULSEWIDTH_BITS  = 12,
    parameter int OUTPUT_BITS      = 12,
    parameter int ACCUMULATOR_BITS = 24,
    localparam int VB = ($clog2(VOICES) > 1) ? $clog2(VOICES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       cfg_we,
    input  logic [VB-1:0]              cfg_voice,
    input  logic [FREQ_BITS-1:0]       cfg_freq,
    input  logic [PULSEWIDTH_BITS-1:0] cfg_pw,
    input  logic [6:0]                 cfg_ctrl,
    output logic [OUTPUT_BITS-1:0]     dout,
    output logic [VB-1:0]              dout_voice,
    output logic                       dout_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int A = ACCUMULATOR_BITS;
    localparam int O = OUTPUT_BITS;
    localparam int P = PULSEWIDTH_BITS;
    localparam logic [22:0] LFSR_SEED = 23'h7FFFFF;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [VB-1:0]         r_vidx;
    logic [VB-1:0]         w_vidx_nxt;
    logic                  w_proc;
    logic                  w_last;
    logic [VB-1:0]         w_src;

    logic [A-1:0]          r_acc  [VOICES];
    logic [22:0]           r_lfsr [VOICES];
    logic [FREQ_BITS-1:0]  r_freq [VOICES];
    logic [P-1:0]          r_pw   [VOICES];
    logic [6:0]            r_ctrl [VOICES];
    logic [VOICES-1:0]     r_ovf;
    logic [VOICES-1:0]     r_msb;

    logic [O-1:0]          r_dout;
    logic [VB-1:0]         r_dout_voice;
    logic                  r_dout_valid;
    logic                  r_overrun;

    logic [A-1:0]          w_acc_old;
    logic [FREQ_BITS-1:0]  w_freq;
    logic [P-1:0]          w_pw;
    logic [6:0]            w_ctrl;
    logic [A:0]            w_sum;
    logic [A-1:0]          w_acc_new;
    logic                  w_ovf_new;
    logic [22:0]           w_lfsr_old;
    logic [22:0]           w_lfsr_new;
    logic                  w_tri_flip;
    logic [O-1:0]          w_saw;
    logic [O-1:0]          w_tri;
    logic [O-1:0]          w_pulse;
    logic [O-1:0]          w_noise;
    logic [O-1:0]          w_wave;

    assign w_last = (r_vidx == VB'(VOICES - 1));
    assign w_src  = (r_vidx == '0) ? VB'(VOICES - 1) : r_vidx - VB'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_vidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_vidx  <= w_vidx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vidx_nxt  = r_vidx;
        w_proc      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_tick) begin
                    w_state_nxt = S_SWEEP;
                    w_vidx_nxt  = '0;
                end
            end
            S_SWEEP: begin
                w_proc = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_vidx_nxt  = '0;
                end else begin
                    w_vidx_nxt = r_vidx + VB'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_acc_old  = r_acc[r_vidx];
    assign w_freq     = r_freq[r_vidx];
    assign w_pw       = r_pw[r_vidx];
    assign w_ctrl     = r_ctrl[r_vidx];
    assign w_lfsr_old = r_lfsr[r_vidx];
    assign w_sum      = {1'b0, w_acc_old} + {{(A + 1 - FREQ_BITS){1'b0}}, w_freq};

    // r_ovf/r_msb of the source voice already hold this sweep's value for v>=1,
    // and the previous sweep's last voice for v=0, simply by processing order.
    always_comb begin
        w_acc_new  = w_sum[A-1:0];
        w_ovf_new  = w_sum[A];
        w_lfsr_new = w_lfsr_old;
        if (w_ctrl[6]) begin
            w_acc_new  = '0;
            w_ovf_new  = 1'b0;
            w_lfsr_new = LFSR_SEED;
        end else begin
            if (w_ctrl[4] && r_ovf[w_src]) begin
                w_acc_new = '0;
                w_ovf_new = 1'b0;
            end
            if (w_acc_new[19] && !w_acc_old[19]) begin
                w_lfsr_new = {w_lfsr_old[21:0], w_lfsr_old[22] ^ w_lfsr_old[17]};
            end
        end
    end

    assign w_tri_flip = w_acc_new[A-1] ^ (w_ctrl[5] & r_msb[w_src]);
    assign w_saw      = w_acc_new[A-1 -: O];
    assign w_tri      = w_tri_flip ? ~w_acc_new[A-2 -: O] : w_acc_new[A-2 -: O];
    assign w_pulse    = (w_acc_new[A-1 -: P] >= w_pw) ? {O{1'b1}} : {O{1'b0}};
    assign w_noise    = w_lfsr_new[22 -: O];

    always_comb begin
        w_wave = {O{1'b1}};
        if (w_ctrl[0]) w_wave = w_wave & w_noise;
        if (w_ctrl[1]) w_wave = w_wave & w_pulse;
        if (w_ctrl[2]) w_wave = w_wave & w_tri;
        if (w_ctrl[3]) w_wave = w_wave & w_saw;
        if (w_ctrl[3:0] == 4'b0000) w_wave = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < VOICES; i++) begin
                r_acc[i]  <= '0;
                r_lfsr[i] <= LFSR_SEED;
                r_freq[i] <= '0;
                r_pw[i]   <= '0;
                r_ctrl[i] <= '0;
            end
            r_ovf <= '0;
            r_msb <= '0;
        end else begin
            if (cfg_we && ({1'b0, cfg_voice} < (VB + 1)'(VOICES))) begin
                r_freq[cfg_voice] <= cfg_freq;
                r_pw[cfg_voice]   <= cfg_pw;
                r_ctrl[cfg_voice] <= cfg_ctrl;
            end
            if (w_proc) begin
                r_acc[r_vidx]  <= w_acc_new;
                r_lfsr[r_vidx] <= w_lfsr_new;
                r_ovf[r_vidx]  <= w_ovf_new;
                r_msb[r_vidx]  <= w_acc_new[A-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_voice <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_dout_valid <= w_proc;
            r_overrun    <= sample_tick && (r_state == S_SWEEP);
            if (w_proc) begin
                r_dout       <= w_wave;
                r_dout_voice <= r_vidx;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_voice = r_dout_voice;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;
    assign busy       = (r_state == S_SWEEP);

endmodule

// File: tb/tb_tone_generator_tdm.sv
// Directed bench for tone_generator_tdm (VOICES=4, 24-bit accumulators, 12-bit output).
module tb_tone_generator_tdm;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic        cfg_we;
    logic [1:0]  cfg_voice;
    logic [15:0] cfg_freq;
    logic [11:0] cfg_pw;
    logic [6:0]  cfg_ctrl;
    logic [11:0] dout;
    logic [1:0]  dout_voice;
    logic        dout_valid;
    logic        busy;
    logic        overrun;

    int          n_checks;
    int          n_fail;

    logic [11:0] sw_out [4];
    int          sw_nvalid;
    int          sw_lat;
    logic        sw_order_ok;
    logic        sw_busy1;

    tone_generator_tdm dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_freq    (cfg_freq),
        .cfg_pw      (cfg_pw),
        .cfg_ctrl    (cfg_ctrl),
        .dout        (dout),
        .dout_voice  (dout_voice),
        .dout_valid  (dout_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] v, input logic [15:0] f,
                             input logic [11:0] pw, input logic [6:0] ctrl);
        cfg_voice = v;
        cfg_freq  = f;
        cfg_pw    = pw;
        cfg_ctrl  = ctrl;
        cfg_we    = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Pulse sample_tick and collect the streamed outputs over a bounded window.
    task automatic do_sweep();
        sw_nvalid   = 0;
        sw_lat      = -1;
        sw_order_ok = 1'b1;
        for (int i = 0; i < 4; i++) sw_out[i] = 12'h0;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        sw_busy1    = busy;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) @(negedge clk);
            if (dout_valid) begin
                if (sw_lat < 0) sw_lat = c;
                if (int'(dout_voice) != sw_nvalid) sw_order_ok = 1'b0;
                if (sw_nvalid < 4) sw_out[sw_nvalid] = dout;
                sw_nvalid++;
            end
        end
    endtask

    task automatic run_pattern(input logic [19:0] tmask, output logic [19:0] vmask,
                               output logic [19:0] omask);
        for (int c = 0; c < 20; c++) begin
            sample_tick = tmask[c];
            vmask[c]    = dout_valid;
            omask[c]    = overrun;
            @(negedge clk);
        end
        sample_tick = 1'b0;
    endtask

    logic [19:0] vm;
    logic [19:0] om;
    int          bad;
    int          cnt;

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        sample_tick = 1'b0;
        cfg_we      = 1'b0;
        cfg_voice   = '0;
        cfg_freq    = '0;
        cfg_pw      = '0;
        cfg_ctrl    = '0;

        // Reset state and basic saw sweep
        do_reset();
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_voice", 32'(dout_voice), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);

        cfg_write(2'd0, 16'h1000, 12'h000, 7'h08);
        for (int n = 1; n <= 3; n++) begin
            do_sweep();
            check("saw_v0", 32'(sw_out[0]), 32'(n));
            check("saw_nvalid", 32'(sw_nvalid), 32'd4);
            check("saw_order", 32'(sw_order_ok), 32'h1);
            if (n == 1) begin
                check("saw_latency", 32'(sw_lat), 32'd2);
                check("saw_busy", 32'(sw_busy1), 32'h1);
                check("silent_v1", 32'(sw_out[1]), 32'h0);
            end
        end

        // Long run: pulse on v0, noise on v1, sync on v2, triangle on v3
        do_reset();
        cfg_write(2'd0, 16'hFFFF, 12'h800, 7'h02);
        cfg_write(2'd1, 16'hFFFF, 12'h000, 7'h01);
        cfg_write(2'd2, 16'h0100, 12'h000, 7'h18);
        cfg_write(2'd3, 16'hFFFF, 12'h000, 7'h04);
        bad = 0;
        for (int n = 1; n <= 257; n++) begin
            do_sweep();
            if (sw_nvalid != 4 || !sw_order_ok) bad++;
            if (n == 128) begin
                check("pulse_low_128", 32'(sw_out[0]), 32'h000);
                check("tri_128", 32'(sw_out[3]), 32'hFFF);
            end
            if (n == 129) begin
                check("pulse_high_129", 32'(sw_out[0]), 32'hFFF);
                check("tri_fall_129", 32'(sw_out[3]), 32'hFE0);
            end
            if (n == 184) check("noise_184", 32'(sw_out[1]), 32'hFFF);
            if (n == 185) check("noise_185", 32'(sw_out[1]), 32'hFFE);
            if (n == 201) check("noise_201", 32'(sw_out[1]), 32'hFFC);
            if (n == 256) check("sync_pre_256", 32'(sw_out[2]), 32'h010);
            if (n == 257) begin
                check("sync_reset_257", 32'(sw_out[2]), 32'h000);
                check("pulse_wrap_257", 32'(sw_out[0]), 32'h000);
                check("noise_257", 32'(sw_out[1]), 32'hFE0);
            end
        end
        check("long_sweeps_ok", 32'(bad), 32'd0);

        // Test bit: hold accumulator, reseed LFSR
        cfg_write(2'd1, 16'hFFFF, 12'h000, 7'h41);
        cfg_write(2'd3, 16'h1234, 12'h000, 7'h48);
        do_sweep();
        check("test_noise_seed", 32'(sw_out[1]), 32'hFFF);
        check("test_saw_hold1", 32'(sw_out[3]), 32'h000);
        do_sweep();
        check("test_saw_hold2", 32'(sw_out[3]), 32'h000);
        cfg_write(2'd1, 16'hFFFF, 12'h000, 7'h01);
        cfg_write(2'd3, 16'h1234, 12'h000, 7'h40);
        do_sweep();
        check("noise_after_test", 32'(sw_out[1]), 32'hFFF);
        check("test_no_wave", 32'(sw_out[3]), 32'h000);
        cfg_write(2'd3, 16'h1234, 12'h000, 7'h08);
        do_sweep();
        check("saw_after_test", 32'(sw_out[3]), 32'h001);

        // Tick spacing: overrun pulses and dropped ticks
        do_reset();
        run_pattern(20'h01249, vm, om);
        check("tick3_valid_mask", 32'(vm), 32'h3CF3C);
        check("tick3_overrun_mask", 32'(om), 32'h00410);
        run_pattern(20'h00031, vm, om);
        check("lastcyc_valid_mask", 32'(vm), 32'h007BC);
        check("lastcyc_overrun_mask", 32'(om), 32'h00020);

        // Reset in the middle of a sweep
        do_reset();
        cfg_write(2'd0, 16'h1000, 12'h000, 7'h08);
        do_sweep();
        do_sweep();
        check("pre_rst_v0", 32'(sw_out[0]), 32'h002);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        check("mid_valid0", 32'({dout_valid, dout_voice, dout}), 32'h4003);
        @(negedge clk);
        check("mid_valid1", 32'({dout_valid, dout_voice}), 32'h5);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 32'(dout_valid), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (dout_valid) cnt++;
        end
        check("rst_mid_no_more", 32'(cnt), 32'd0);
        cfg_write(2'd0, 16'h1000, 12'h000, 7'h08);
        do_sweep();
        check("post_rst_v0", 32'(sw_out[0]), 32'h001);
        check("post_rst_nvalid", 32'(sw_nvalid), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
